// File: rtl/wb_writer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_writer_pkg : shared widths and queued write-back entry type       |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package wb_writer_pkg;

  localparam int c_reg_w  = 5;
  localparam int c_data_w = 32;

  typedef struct packed {
    logic [c_reg_w-1:0]  rd;
    logic [c_data_w-1:0] data;
    logic                live;
  } wb_entry;

  function automatic logic [31:0] reg_onehot(input logic [c_reg_w-1:0] r);
    reg_onehot = 32'd1 << r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_fifo  : long-latency result queue exposing per-slot dest and live |
// |            flags; WB_WAW_KILL_EN adds destination-matched kill       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module wb_fifo
  import wb_writer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [c_reg_w-1:0]         push_reg,
  input  logic [c_data_w-1:0]        push_data,
  input  logic                       pop,
`ifdef WB_WAW_KILL_EN
  input  logic                       kill,
  input  logic [c_reg_w-1:0]         kill_reg,
`endif
  output logic                       full,
  output logic                       empty,
  output logic [c_reg_w-1:0]         head_reg,
  output logic [c_data_w-1:0]        head_data,
  output logic                       head_live,
  output logic [DEPTH*c_reg_w-1:0]   ent_reg,
  output logic [DEPTH-1:0]           ent_live
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw-1:0]        r_rptr;
  logic [c_aw-1:0]        r_wptr;
  logic [c_aw:0]          r_count;
  wb_entry [DEPTH-1:0]    w_slots;

  assign full      = (r_count == (c_aw+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign head_reg  = w_slots[r_rptr].rd;
  assign head_data = w_slots[r_rptr].data;
  assign head_live = w_slots[r_rptr].live;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + c_aw'(1);
      if (pop)  r_rptr <= r_rptr + c_aw'(1);
      if (push && !pop)      r_count <= r_count + (c_aw+1)'(1);
      else if (!push && pop) r_count <= r_count - (c_aw+1)'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      wb_entry         r_slot;
      logic [c_aw-1:0] w_off;
      logic            w_occ;

      // A slot is occupied when its distance from the read pointer is below the count.
      assign w_off = c_aw'(gi) - r_rptr;
      assign w_occ = ({1'b0, w_off} < r_count);

      // Push wins over a same-cycle kill so the newly written entry stays live.
      always_ff @(posedge clk) begin
        if (push && (r_wptr == c_aw'(gi)))
          r_slot <= '{rd: push_reg, data: push_data, live: 1'b1};
`ifdef WB_WAW_KILL_EN
        else if (kill && w_occ && (r_slot.rd == kill_reg))
          r_slot.live <= 1'b0;
`endif
      end

      assign w_slots[gi]                     = r_slot;
      assign ent_reg[gi*c_reg_w +: c_reg_w]  = r_slot.rd;
      assign ent_live[gi]                    = w_occ & r_slot.live;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_writer : register-file write-back arbiter, in-order pipe beats a  |
// |             queued long-latency unit; WB_WAW_KILL_EN = WAW cancel    |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pipe_valid,
  input  logic [4:0]          pipe_reg,
  input  logic [31:0]         pipe_data,
  input  logic                lu_valid,
  input  logic [4:0]          lu_reg,
  input  logic [31:0]         lu_data,
  output logic                lu_ready,
  output logic                regWrite,
  output logic [4:0]          writeReg,
  output logic [31:0]         writeData,
  output logic [31:0]         pend_mask
);

  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [c_reg_w-1:0]        w_head_reg;
  logic [c_data_w-1:0]       w_head_data;
  logic                      w_head_live;
  logic [DEPTH*c_reg_w-1:0]  w_ent_reg;
  logic [DEPTH-1:0]          w_ent_live;

  assign lu_ready = !w_full;
  assign w_push   = lu_valid & lu_ready;
  assign w_pop    = !pipe_valid & !w_empty;

  wb_fifo #(
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_reg  (lu_reg),
    .push_data (lu_data),
    .pop       (w_pop),
`ifdef WB_WAW_KILL_EN
    .kill      (pipe_valid),
    .kill_reg  (pipe_reg),
`endif
    .full      (w_full),
    .empty     (w_empty),
    .head_reg  (w_head_reg),
    .head_data (w_head_data),
    .head_live (w_head_live),
    .ent_reg   (w_ent_reg),
    .ent_live  (w_ent_live)
  );

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_live[i])
        pend_mask = pend_mask | reg_onehot(w_ent_reg[i*c_reg_w +: c_reg_w]);
    end
    pend_mask[0] = 1'b0;
  end

  // Register 0 writes are consumed like any other but never enable the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (pipe_valid) begin
      regWrite  <= (pipe_reg != '0);
      writeReg  <= pipe_reg;
      writeData <= pipe_data;
    end else if (w_pop) begin
      regWrite  <= w_head_live && (w_head_reg != '0);
      writeReg  <= w_head_reg;
      writeData <= w_head_data;
    end else begin
      regWrite  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_writer : directed self-checking bench for wb_writer            |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_wb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] pend_mask;

  logic [31:0] rf [32];
  int          n_total = 0;
  int          n_pass  = 0;
  int          rw_cnt;

  wb_writer #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_valid (pipe_valid),
    .pipe_reg   (pipe_reg),
    .pipe_data  (pipe_data),
    .lu_valid   (lu_valid),
    .lu_reg     (lu_reg),
    .lu_data    (lu_data),
    .lu_ready   (lu_ready),
    .regWrite   (regWrite),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .pend_mask  (pend_mask)
  );

  always #5 clk = ~clk;

  // Register file model: writes on the falling edge, as the real one does.
  always @(negedge clk) begin
    if (regWrite) rf[writeReg] = writeData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    pipe_valid = 0; pipe_reg = 0; pipe_data = 0;
    lu_valid = 0; lu_reg = 0; lu_data = 0;
    rst = 1;
    #1;
    check("rst_rw", {31'd0, regWrite}, 32'd0);
    check("rst_wr", {27'd0, writeReg}, 32'd0);
    check("rst_wd", writeData, 32'd0);
    check("rst_pend", pend_mask, 32'd0);
    check("rst_rdy", {31'd0, lu_ready}, 32'd1);
    tick(); tick();
    rst = 0;

    // Pipe write: visible one cycle later, then held with regWrite low.
    pipe_valid = 1; pipe_reg = 5; pipe_data = 32'h7;
    tick();
    pipe_valid = 0;
    check("pipe_rw", {31'd0, regWrite}, 32'd1);
    check("pipe_wr", {27'd0, writeReg}, 32'd5);
    check("pipe_wd", writeData, 32'h7);
    tick();
    check("idle_rw", {31'd0, regWrite}, 32'd0);
    check("idle_wr", {27'd0, writeReg}, 32'd5);
    check("idle_wd", writeData, 32'h7);

    // Long-latency result with pipe idle: two cycles to the outputs.
    lu_valid = 1; lu_reg = 3; lu_data = 32'hDEADBEEF;
    check("lu_rdy", {31'd0, lu_ready}, 32'd1);
    tick();
    lu_valid = 0;
    check("lu_pend", pend_mask, 32'h8);
    check("lu_rw0", {31'd0, regWrite}, 32'd0);
    tick();
    check("lu_rw", {31'd0, regWrite}, 32'd1);
    check("lu_wr", {27'd0, writeReg}, 32'd3);
    check("lu_wd", writeData, 32'hDEADBEEF);
    check("lu_pend0", pend_mask, 32'd0);

    // Destination 0 from the pipe is consumed but not written.
    pipe_valid = 1; pipe_reg = 0; pipe_data = 32'h1234;
    tick();
    pipe_valid = 0;
    check("r0_rw", {31'd0, regWrite}, 32'd0);
    check("r0_wd", writeData, 32'h1234);
    check("r0_rdy", {31'd0, lu_ready}, 32'd1);

    // Pipe busy 4 cycles while lu offers regs 20,21,22: FIFO fills after 2 accepts.
    for (int i = 0; i < 4; i++) begin
      pipe_valid = 1; pipe_reg = 5'(10 + i); pipe_data = 32'hA0 + i;
      lu_valid = 1; lu_reg = (i < 2) ? 5'(20 + i) : 5'd22; lu_data = (i < 2) ? 32'hB0 + i : 32'hB2;
      check($sformatf("bp_rdy%0d", i), {31'd0, lu_ready}, (i < 2) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("bp_wr%0d", i), {27'd0, writeReg}, 32'(10 + i));
      check($sformatf("bp_wd%0d", i), writeData, 32'hA0 + i);
    end
    check("bp_pend", pend_mask, 32'h0030_0000);
    pipe_valid = 0;
    check("bp_full", {31'd0, lu_ready}, 32'd0);
    tick();
    check("bp_q0_wr", {27'd0, writeReg}, 32'd20);
    check("bp_q0_wd", writeData, 32'hB0);
    check("bp_q0_rdy", {31'd0, lu_ready}, 32'd1);
    tick();
    lu_valid = 0;
    check("bp_q1_wr", {27'd0, writeReg}, 32'd21);
    check("bp_q1_wd", writeData, 32'hB1);
    check("bp_q1_pend", pend_mask, 32'h0040_0000);
    tick();
    check("bp_q2_wr", {27'd0, writeReg}, 32'd22);
    check("bp_q2_wd", writeData, 32'hB2);
    check("bp_q2_rw", {31'd0, regWrite}, 32'd1);
    check("bp_q2_pend", pend_mask, 32'd0);

    // WAW: queue reg 8, then a pipe write to reg 8.
    lu_valid = 1; lu_reg = 8; lu_data = 32'h99;
    tick();
    lu_valid = 0;
    pipe_valid = 1; pipe_reg = 8; pipe_data = 32'h11;
    check("waw_pend", pend_mask, 32'h100);
    tick();
    pipe_valid = 0;
    check("waw_pipe_wd", writeData, 32'h11);
`ifdef WB_WAW_KILL_EN
    check("waw_kill_pend", pend_mask, 32'd0);
    tick();
    check("waw_q_rw", {31'd0, regWrite}, 32'd0);
    tick();
    check("waw_rf8", rf[8], 32'h11);

    // Kill and same-destination push in one cycle: new entry survives.
    lu_valid = 1; lu_reg = 9; lu_data = 32'h90;
    tick();
    pipe_valid = 1; pipe_reg = 9; pipe_data = 32'h91;
    lu_valid = 1; lu_reg = 9; lu_data = 32'h92;
    tick();
    pipe_valid = 0; lu_valid = 0;
    check("kp_pend", pend_mask, 32'h200);
    tick();
    check("kp_old_rw", {31'd0, regWrite}, 32'd0);
    tick();
    check("kp_new_rw", {31'd0, regWrite}, 32'd1);
    check("kp_new_wd", writeData, 32'h92);
    tick();
    check("kp_rf9", rf[9], 32'h92);
`else
    check("waw_keep_pend", pend_mask, 32'h100);
    tick();
    check("waw_q_rw", {31'd0, regWrite}, 32'd1);
    check("waw_q_wd", writeData, 32'h99);
    tick();
    check("waw_rf8", rf[8], 32'h99);
`endif

    // Queue two entries behind a busy pipe, then reset mid-operation.
    pipe_valid = 1; pipe_reg = 1; pipe_data = 32'h1;
    lu_valid = 1; lu_reg = 4; lu_data = 32'h44;
    tick();
    pipe_reg = 2; pipe_data = 32'h2;
    lu_reg = 6; lu_data = 32'h66;
    tick();
    check("pre_rst_pend", pend_mask, 32'h50);
    check("pre_rst_rdy", {31'd0, lu_ready}, 32'd0);
    pipe_valid = 0; lu_valid = 0;
    rst = 1;
    #1;
    check("mid_rst_rw", {31'd0, regWrite}, 32'd0);
    check("mid_rst_wr", {27'd0, writeReg}, 32'd0);
    check("mid_rst_wd", writeData, 32'd0);
    check("mid_rst_pend", pend_mask, 32'd0);
    check("mid_rst_rdy", {31'd0, lu_ready}, 32'd1);
    tick();
    rst = 0;
    rw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      rw_cnt += int'(regWrite);
    end
    check("post_rst_writes", 32'(rw_cnt), 32'd0);
    check("post_rst_rf4", rf[4], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
